// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM with byte-lane writes plus an MMIO window holding a UART TX (with FIFO) and a cycle counter
module dmem_mmio #(
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = "",
  parameter int    FIFO_DEPTH  = 16,
  parameter int    CLK_DIV     = 868
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_write,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [31:0] ram [DEPTH_WORDS];
  logic [7:0] fifo [FIFO_DEPTH];
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, overflow_q, overflow_d;
  logic [FA-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FA:0] count_q, count_d;
  logic [31:0] cycle_q, cycle_d, rdata_q, rdata_d, mmio_rd;
  logic [AW-1:0] idx;
  logic is_mmio, push_req, push, pop, full, nonempty, busy, idle, bit_end, ovf_clr;
  logic unused_addr;

  assign idx = mem_addr[AW+1:2];
  assign is_mmio = mem_addr[31];
  assign unused_addr = ^{mem_addr[30:AW+2], mem_addr[1:0]};
  assign full = count_q == (FA+1)'(FIFO_DEPTH);
  assign nonempty = count_q != '0;
  assign busy = state_q != IDLE;
  assign idle = !nonempty && !busy;
  assign bit_end = baud_q == '0;
  assign push_req = is_mmio && mem_addr[3:2] == 2'd0 && mem_write[0];
  assign push = push_req && !full;
  assign ovf_clr = is_mmio && mem_addr[3:2] == 2'd1 && mem_write[0] && mem_wdata[3];
  assign mem_rdata = rdata_q;
  assign uart_tx = tx_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = nonempty ? START : IDLE;
      START:   state_d = bit_end ? DATA : START;
      DATA:    state_d = (bit_end && bit_q == 3'd7) ? STOP : DATA;
      default: state_d = bit_end ? (nonempty ? START : IDLE) : STOP;
    endcase
  end

  // The end of a stop bit pops straight into the next start bit, so frames run back to back.
  always_comb begin
    pop = nonempty && (state_q == IDLE || (state_q == STOP && bit_end));
    baud_d = state_d == IDLE ? '0 : bit_end ? BW'(CLK_DIV - 1) : baud_q - 1'b1;
    bit_d = (state_q == DATA && bit_end) ? bit_q + 3'd1 : bit_q;
    shift_d = pop ? fifo[rd_q] : (state_q == DATA && bit_end) ? shift_q >> 1 : shift_q;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end

  always_comb begin
    wr_d = push ? wr_q + FA'(1) : wr_q;
    rd_d = pop ? rd_q + FA'(1) : rd_q;
    count_d = count_q + (FA+1)'(push) - (FA+1)'(pop);
    overflow_d = (push_req && full) || (overflow_q && !ovf_clr);
    cycle_d = cycle_q + 32'd1;
    mmio_rd = mem_addr[3:2] == 2'd1 ? {28'b0, overflow_q, idle, busy, full} :
              mem_addr[3:2] == 2'd2 ? cycle_q : '0;
    rdata_d = is_mmio ? mmio_rd : ram[idx];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      cycle_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      cycle_q <= cycle_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (!is_mmio && mem_write[i]) ram[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (push) fifo[wr_q] <= mem_wdata[7:0];
  end
endmodule
